// File: rtl/scan_decode_mux.sv
// N:1 registered decode-mux with a scan sequencer that fills a snapshot word.
// Define SCAN_PARITY_EN to register XOR parity of each completed snapshot.
module scan_decode_mux #(
  parameter int SEL_W = 3,
  parameter int DWELL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2**SEL_W-1:0]   x,
  input  logic [SEL_W-1:0]      y,
  input  logic                  mode,
  input  logic                  start,
  output logic                  z,
  output logic [SEL_W-1:0]      cur_sel,
  output logic [2**SEL_W-1:0]   snap,
  output logic                  busy,
  output logic                  done,
  output logic                  parity
);

  localparam int N  = 2**SEL_W;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]    LAST = CW'(DWELL - 1);
  localparam logic [SEL_W-1:0] TOP  = SEL_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

`ifdef SCAN_PARITY_EN
  logic         par_q;
  logic [N-1:0] snap_nx;

  // snapshot as it will look after this edge's capture
  always_comb begin
    snap_nx          = snap;
    snap_nx[cur_sel] = x[cur_sel];
  end

  assign parity = par_q;
`else
  assign parity = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      z       <= 1'b0;
      cur_sel <= '0;
      snap    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SCAN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (!mode) begin
            z       <= x[y];
            cur_sel <= y;
          end else if (start) begin
            state   <= SCAN;
            busy    <= 1'b1;
            cur_sel <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            z       <= x[cur_sel];
          end else begin
            z <= x[cur_sel];
          end
        end
        SCAN: begin
          if (!mode) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            z       <= x[y];
            cur_sel <= y;
          end else begin
            z <= x[cur_sel];
            if (cnt == LAST) begin
              snap[cur_sel] <= x[cur_sel];
              cnt           <= '0;
              cur_sel       <= cur_sel + 1'b1;
              if (cur_sel == TOP) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
`ifdef SCAN_PARITY_EN
                par_q <= ^snap_nx;
`endif
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          z     <= x[cur_sel];
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_decode_mux.sv
// Scoreboard bench for scan_decode_mux: DWELL=1 and DWELL=2 instances
// share one stimulus stream; each test checks the instance it targets.
module tb_scan_decode_mux;

  logic       clk = 1'b0;
  logic       reset, mode, start;
  logic [7:0] x;
  logic [2:0] y;

  logic       z1, b1, d1, p1;
  logic [2:0] c1;
  logic [7:0] s1;
  logic       z2, b2, d2, p2;
  logic [2:0] c2;
  logic [7:0] s2;

  int total = 0;
  int bad   = 0;

`ifdef SCAN_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  scan_decode_mux #(.SEL_W(3), .DWELL(1)) u_d1 (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .mode(mode), .start(start), .z(z1), .cur_sel(c1),
    .snap(s1), .busy(b1), .done(d1), .parity(p1)
  );

  scan_decode_mux #(.SEL_W(3), .DWELL(2)) u_d2 (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .mode(mode), .start(start), .z(z2), .cur_sel(c2),
    .snap(s2), .busy(b2), .done(d2), .parity(p2)
  );

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq(e.tag, got, e.v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    check_eq({tag, "_z"},   32'(z1), 0);
    check_eq({tag, "_cs"},  32'(c1), 0);
    check_eq({tag, "_sn"},  32'(s1), 0);
    check_eq({tag, "_bz"},  32'(b1), 0);
    check_eq({tag, "_dn"},  32'(d1), 0);
    check_eq({tag, "_par"}, 32'(p1), 0);
  endtask

  // start a scan at edge k, then observe 24 cycles (sample c follows edge k+c)
  task automatic scan_run(input bit use2, input logic [7:0] x0,
                          input int chg_at, input logic [7:0] x1,
                          input bit hold, output int nbusy,
                          output int done_at, output int ndone);
    bit   prev;
    logic bb, dd;
    x     = x0;
    mode  = 1'b1;
    start = 1'b1;
    tick;
    if (!hold) start = 1'b0;
    nbusy   = 0;
    done_at = -1;
    ndone   = 0;
    prev    = 1'b0;
    for (int c = 0; c < 24; c++) begin
      bb = use2 ? b2 : b1;
      dd = use2 ? d2 : d1;
      if (bb) nbusy++;
      if (dd) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (c == chg_at) x = x1;
      if (prev) start = 1'b0;
      prev = dd;
      tick;
    end
    start = 1'b0;
  endtask

  task automatic scan_test(input string tag, input bit use2,
                           input logic [7:0] x0, input int chg_at,
                           input logic [7:0] x1, input bit hold,
                           input int span, input logic [7:0] esnap);
    int nb, da, nd;
    push({tag, "_busy"},  span);
    push({tag, "_done"},  span);
    push({tag, "_ndone"}, 1);
    push({tag, "_snap"},  esnap);
    push({tag, "_par"},   32'(PEN & (^esnap)));
    scan_run(use2, x0, chg_at, x1, hold, nb, da, nd);
    pop_chk(nb);
    pop_chk(da);
    pop_chk(nd);
    pop_chk(use2 ? 32'(s2) : 32'(s1));
    pop_chk(use2 ? 32'(p2) : 32'(p1));
  endtask

  initial begin
    logic [7:0] xa;
    int         nd;

    reset = 1'b1;
    x     = 8'hFF;
    mode  = 1'b1;
    start = 1'b1;
    y     = '0;
    tick;
    tick;
    chk_reset("rst");
    check_eq("rst_sn2", 32'(s2), 0);
    check_eq("rst_bz2", 32'(b2), 0);

    reset = 1'b0;
    mode  = 1'b0;
    start = 1'b0;
    tick;

    xa = 8'b1010_0110;
    x  = xa;
    for (int i = 0; i < 8; i++) begin
      y     = 3'(i);
      start = 1'(i & 1);
      push("dir_z", 32'(xa[i]));
      push("dir_cs", i);
      tick;
      pop_chk(32'(z1));
      pop_chk(32'(c1));
    end
    start = 1'b0;

    scan_test("scan1", 1'b0, 8'hA5, -1, 8'h00, 1'b1, 8, 8'hA5);
    scan_test("scan01", 1'b0, 8'h01, -1, 8'h00, 1'b0, 8, 8'h01);
    scan_test("dwell2", 1'b1, 8'h00, 5, 8'hFF, 1'b0, 16, 8'hFC);

    scan_test("pre_ab", 1'b0, 8'hF0, -1, 8'h00, 1'b0, 8, 8'hF0);
    x     = 8'h0F;
    y     = 3'd2;
    mode  = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    check_eq("ab_busy_pre", 32'(b1), 1);
    mode = 1'b0;
    tick;
    check_eq("ab_busy", 32'(b1), 0);
    check_eq("ab_done", 32'(d1), 0);
    check_eq("ab_snap", 32'(s1), 32'h00F7);
    check_eq("ab_par",  32'(p1), 32'(PEN & (^8'hF0)));
    check_eq("ab_z",    32'(z1), 1);
    check_eq("ab_cs",   32'(c1), 2);
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      if (d1) nd++;
      tick;
    end
    check_eq("ab_nodone", nd, 0);

    x     = 8'hFF;
    mode  = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    reset = 1'b1;
    tick;
    chk_reset("mid_rst");
    check_eq("mid_rst_bz2", 32'(b2), 0);
    reset = 1'b0;
    scan_test("clean", 1'b0, 8'h3C, -1, 8'h00, 1'b0, 8, 8'h3C);

    check_eq("sb_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_decode_mux.md
Name: scan_decode_mux

Overview:
Parametrised, registered successor to the 8:1 decode-mux lab block. It selects one bit of an N-bit input word, N = 2**SEL_W, and drives it to a registered output.
- Direct mode: the select is external.
- Scan mode: an internal sequencer steps through every channel, holds each for DWELL cycles, and captures each channel into a snapshot register.
- Sits between switch/sensor inputs and downstream logic that needs either a single bit or a complete sampled word.

Parameters:
SEL_W, 3, select width; channel count N = 2**SEL_W
DWELL, 1, cycles spent on each channel in scan mode; must be >= 1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
x  in  N  data channels; channel i is x[i]
y  in  SEL_W  channel select, used in direct mode
mode  in  1  0 = direct, 1 = scan
start  in  1  begins a scan; sampled only in IDLE with mode=1
z  out  1  registered selected bit
cur_sel  out  SEL_W  channel currently driven to z
snap  out  N  scan snapshot register
busy  out  1  high while a scan is in progress
done  out  1  one-cycle pulse when a scan completes
parity  out  1  snapshot parity (see Optional Feature)

Behaviour:
- Reset, on a synchronous clk edge with reset=1:
  - z=0, cur_sel=0, snap=0, busy=0, done=0, parity=0.
  - State = IDLE; dwell counter = 0.
  - Reset has priority over every other input, including mid-scan.
- States: IDLE, SCAN, DONE.
- IDLE, mode=0 (direct):
  - Every edge: z <= x[y], cur_sel <= y.
  - Latency is one cycle.
  - start is ignored.
- IDLE, mode=1, start=0:
  - z <= x[cur_sel]; cur_sel holds.
- IDLE, mode=1, start=1, accepted at edge k:
  - Next state SCAN; busy <= 1; cur_sel <= 0; dwell counter <= 0; done <= 0.
- SCAN, each edge:
  - z <= x[cur_sel].
  - Dwell counter increments.
- SCAN, edge where the dwell counter equals DWELL-1:
  - snap[cur_sel] <= x[cur_sel]; dwell counter <= 0; cur_sel increments modulo N.
  - If cur_sel was N-1: next state DONE, busy <= 0, done <= 1. cur_sel wraps to 0.
- Scan timing:
  - Captures occur at edges k+DWELL, k+2*DWELL, ..., k+N*DWELL.
  - done is high for exactly one cycle following edge k+N*DWELL.
  - busy is high for exactly N*DWELL cycles.
- DONE:
  - Unconditional return to IDLE on the next edge; done <= 0.
  - start in DONE is ignored; a new scan requires start to be high in IDLE.
- Scan bits not captured in the current scan keep their previous values; snap is never cleared except by reset.
- start while busy: ignored, no restart.
- mode dropped to 0 during SCAN (abort):
  - Next edge: state IDLE, busy <= 0, done stays 0.
  - snap keeps the bits captured so far.
  - Direct behaviour resumes from that edge, i.e. z <= x[y].
- Width rules:
  - Dwell counter width is max(1, clog2(DWELL)).
  - cur_sel increment is SEL_W wide with natural wrap.

Optional Feature:
Macro SCAN_PARITY_EN.
- Defined:
  - At the edge that enters DONE, parity <= XOR of the complete new snapshot, i.e. snap including the bit captured on that edge.
  - parity holds until the next completed scan or reset.
  - An aborted scan does not update parity.
- Undefined: parity is tied to 0.
- The port list is identical in both builds.

Test Plan:
1. Reset: x=8'hFF, mode=1, start=1, reset=1 for 2 cycles -> z=0, cur_sel=0, snap=8'h00, busy=0, done=0, parity=0.
2. Direct sweep: SEL_W=3, mode=0, x=8'b1010_0110, y stepped 0..7, one value per cycle -> z one cycle later = 0,1,1,0,0,1,0,1; cur_sel follows y.
3. Full scan: DWELL=1, x=8'hA5, start pulsed at edge k:
   - busy high for 8 cycles.
   - done high only after edge k+8.
   - snap=8'hA5.
   - parity=0 with macro, 0 without.
   - A second start held through DONE is ignored.
4. Dwell and changing data: DWELL=2, x=8'h00, then x=8'hFF set 5 cycles after start:
   - busy 16 cycles.
   - snap = 8'hFC (channels 0,1 captured at edges k+2 and k+4 before the change).
   - parity=0 with macro.
5. Abort: DWELL=1, x=8'h0F, snap previously 8'hF0, mode dropped after the 3rd capture -> busy=0 next cycle, no done pulse, snap=8'hF7, parity unchanged.
6. Reset mid-scan: reset=1 at the 4th scan edge -> all outputs return to reset values at that edge; a later start runs a full clean scan.
